// File: rtl/miter_stim_gen_if.sv
// ---------------------------------------------------------------------------
// miter_stim_gen_if
//
// Stimulus handshake bundle between the miter stimulus generator (producer)
// and the vector sink (clock-gating shim or checker).
//
// Signals:
//   valid    producer -> sink  a vector is presented on wire0..wire3
//   ready    sink -> producer  sink accepts the presented vector this cycle
//   wire0    producer -> sink  16-bit stimulus word
//   wire1    producer -> sink  10-bit stimulus word
//   wire2    producer -> sink   6-bit stimulus word
//   wire3    producer -> sink  13-bit stimulus word
//   vec_idx  producer -> sink  index of the presented vector, counted from 0
//
// Modports:
//   master   stimulus generator side
//   slave    vector sink side
// ---------------------------------------------------------------------------
interface miter_stim_gen_if;

    logic        valid;
    logic        ready;
    logic [15:0] wire0;
    logic [9:0]  wire1;
    logic [5:0]  wire2;
    logic [12:0] wire3;
    logic [15:0] vec_idx;

    modport master (
        output valid,
        output wire0,
        output wire1,
        output wire2,
        output wire3,
        output vec_idx,
        input  ready
    );

    modport slave (
        input  valid,
        input  wire0,
        input  wire1,
        input  wire2,
        input  wire3,
        input  vec_idx,
        output ready
    );

endinterface

// File: rtl/miter_stim_gen.sv
// ---------------------------------------------------------------------------
// miter_stim_gen
//
// Pseudo-random stimulus source for the equivalence miter harness. A Galois
// LFSR (right-shift form) is loaded from a seed on an accepted start and
// steps once per accepted vector, producing a reproducible sequence of
// num_vec input bundles for both design copies.
//
// Ports:
//   clk      single clock, all logic on posedge
//   rst_n    asynchronous active-low reset
//   start    one-cycle pulse; honoured only in IDLE or DONE
//   seed     initial LFSR state, sampled on an accepted start
//   num_vec  number of vectors to emit, sampled on an accepted start
//   busy     high while vectors are being emitted (RUN)
//   done     high in DONE; cleared by the next accepted start
//   stim     producer side of the stimulus handshake
//              valid/ready, wire0..wire3 taken from the LFSR, vec_idx
//
// Every output comes straight from a flop; nothing is combinational from
// ready or start.
// ---------------------------------------------------------------------------
module miter_stim_gen #(
    parameter int                 LFSR_W       = 48,
    parameter logic [LFSR_W-1:0]  TAPS         = 48'hC000_0018_0000,
    parameter logic [LFSR_W-1:0]  DEFAULT_SEED = 48'h0000_0000_0001
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LFSR_W-1:0]    seed,
    input  logic [15:0]          num_vec,
    output logic                 busy,
    output logic                 done,
    miter_stim_gen_if.master     stim
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q,   state_d;
    logic [LFSR_W-1:0]   lfsr_q,    lfsr_d;
    logic [15:0]         cnt_max_q, cnt_max_d;
    logic [15:0]         vec_idx_q, vec_idx_d;
    logic                valid_q,   valid_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;

    logic                start_ok;
    logic                xfer;
    logic                last_vec;
    logic [LFSR_W-1:0]   lfsr_step;
    logic [LFSR_W-1:0]   seed_eff;

    // -----------------------------------------------------------------------
    // Galois LFSR step, right-shift form: every bit takes its upper
    // neighbour, and when the bit shifted out (lfsr[0]) is 1 the tap mask is
    // folded in. The MSB has no upper neighbour and only sees its tap.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < LFSR_W - 1; gi++) begin : g_lfsr_bit
            assign lfsr_step[gi] = lfsr_q[gi+1] ^ (lfsr_q[0] & TAPS[gi]);
        end
    endgenerate
    assign lfsr_step[LFSR_W-1] = lfsr_q[0] & TAPS[LFSR_W-1];

    // An all-zero state would lock the LFSR at zero forever.
    assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;

    // A start pulse arriving while vectors are in flight is dropped so the
    // sink never sees a sequence restart mid-stream.
    assign start_ok = start && (state_q != ST_RUN);
    assign xfer     = (state_q == ST_RUN) && valid_q && stim.ready;
    assign last_vec = (vec_idx_q == cnt_max_q);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        cnt_max_d = cnt_max_q;
        vec_idx_d = vec_idx_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = done_q;

        if (start_ok) begin
            lfsr_d    = seed_eff;
            // num_vec=0 wraps this to 16'hFFFF, but that sequence goes
            // straight to DONE and never compares against cnt_max.
            cnt_max_d = num_vec - 16'd1;
            vec_idx_d = 16'd0;
            if (num_vec == 16'd0) begin
                state_d = ST_DONE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
                valid_d = 1'b1;
                busy_d  = 1'b1;
                done_d  = 1'b0;
            end
        end else if (xfer) begin
            if (last_vec) begin
                // The final vector's LFSR state and index stay visible so the
                // harness can read where the sequence ended.
                state_d = ST_DONE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                lfsr_d    = lfsr_step;
                vec_idx_d = vec_idx_q + 16'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= '0;
            cnt_max_q <= 16'd0;
            vec_idx_q <= 16'd0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            cnt_max_q <= cnt_max_d;
            vec_idx_q <= vec_idx_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Stimulus words are fixed slices of the LFSR state; they only move on a
    // transfer or a start, so backpressure holds them stable for free.
    assign stim.valid   = valid_q;
    assign stim.vec_idx = vec_idx_q;
    assign stim.wire0   = lfsr_q[15:0];
    assign stim.wire1   = lfsr_q[25:16];
    assign stim.wire2   = lfsr_q[31:26];
    assign stim.wire3   = lfsr_q[44:32];
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_miter_stim_gen.sv
module tb_miter_stim_gen;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [47:0] seed  = 48'd0;
    logic [15:0] num_vec = 16'd0;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int xfer_log[$];

    miter_stim_gen_if stim_bus ();

    miter_stim_gen #(
        .LFSR_W       (48),
        .TAPS         (48'hC000_0018_0000),
        .DEFAULT_SEED (48'h0000_0000_0001)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .seed    (seed),
        .num_vec (num_vec),
        .busy    (busy),
        .done    (done),
        .stim    (stim_bus)
    );

    always #5 clk = ~clk;

    // Observation bundle: {valid, vec_idx, wire0, wire1, wire2, wire3}
    logic [61:0] obs;
    logic [1:0]  flags;   // {busy, done}
    assign obs   = {stim_bus.valid, stim_bus.vec_idx, stim_bus.wire0,
                    stim_bus.wire1, stim_bus.wire2, stim_bus.wire3};
    assign flags = {busy, done};

    // Hand-computed vectors. seed=1: v0 = 1; v1 = (0) ^ TAPS = C000_0018_0000;
    // v2 = v1 >> 1 = 6000_000C_0000.
    localparam logic [61:0] V0    = {1'b1, 16'd0, 16'h0001, 10'h000, 6'h00, 13'h0000};
    localparam logic [61:0] V1    = {1'b1, 16'd1, 16'h0000, 10'h018, 6'h00, 13'h0000};
    localparam logic [61:0] V2    = {1'b1, 16'd2, 16'h0000, 10'h00C, 6'h00, 13'h0000};
    localparam logic [61:0] V0_D  = {1'b0, 16'd0, 16'h0001, 10'h000, 6'h00, 13'h0000};
    localparam logic [61:0] V1_D  = {1'b0, 16'd1, 16'h0000, 10'h018, 6'h00, 13'h0000};
    localparam logic [61:0] V2_D  = {1'b0, 16'd2, 16'h0000, 10'h00C, 6'h00, 13'h0000};
    // seed=1234_5678_9ABC: [15:0]=9ABC, [25:16]=278, [31:26]=15, [44:32]=1234
    localparam logic [61:0] VX    = {1'b1, 16'd0, 16'h9ABC, 10'h278, 6'h15, 13'h1234};
    localparam logic [61:0] VX_D  = {1'b0, 16'd0, 16'h9ABC, 10'h278, 6'h15, 13'h1234};

    // One line per accepted vector.
    always @(posedge clk) begin
        if (rst_n && stim_bus.valid && stim_bus.ready) begin
            $display("xfer idx=%0d w0=%h w1=%h w2=%h w3=%h", stim_bus.vec_idx,
                     stim_bus.wire0, stim_bus.wire1, stim_bus.wire2, stim_bus.wire3);
            xfer_log.push_back(int'(stim_bus.vec_idx));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_bus.ready = 1'b0;
        #1;
        if (obs !== 62'd0) begin errors++; $display("FAIL reset_obs: got %h expected %h", obs, 62'd0); end
        checks++;
        if (flags !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected %b", flags, 2'b00); end
        checks++;
        tick(); tick();
        rst_n = 1'b1;
        // Load something nonzero, then reset asynchronously mid-cycle.
        seed = 48'd1; num_vec = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        if (obs !== V0) begin errors++; $display("FAIL reset_preload: got %h expected %h", obs, V0); end
        checks++;
        #3;
        rst_n = 1'b0;
        #1;
        if (obs !== 62'd0) begin errors++; $display("FAIL reset_async_obs: got %h expected %h", obs, 62'd0); end
        checks++;
        if (flags !== 2'b00) begin errors++; $display("FAIL reset_async_flags: got %b expected %b", flags, 2'b00); end
        checks++;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if ({obs, flags} !== 64'd0) begin
                errors++;
                $display("FAIL reset_idle_cyc%0d: got %h expected %h", i, {obs, flags}, 64'd0);
            end
            checks++;
        end
    endtask

    task automatic test_basic_seq();
        seed = 48'd1; num_vec = 16'd2; stim_bus.ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        if (obs !== V0) begin errors++; $display("FAIL basic_vec0: got %h expected %h", obs, V0); end
        checks++;
        if (flags !== 2'b10) begin errors++; $display("FAIL basic_busy: got %b expected %b", flags, 2'b10); end
        checks++;
        tick();
        if (obs !== V1) begin errors++; $display("FAIL basic_vec1: got %h expected %h", obs, V1); end
        checks++;
        tick();
        if (obs !== V1_D) begin errors++; $display("FAIL basic_done_obs: got %h expected %h", obs, V1_D); end
        checks++;
        if (flags !== 2'b01) begin errors++; $display("FAIL basic_done_flags: got %b expected %b", flags, 2'b01); end
        checks++;
        tick();
        if (obs !== V1_D) begin errors++; $display("FAIL basic_done_hold: got %h expected %h", obs, V1_D); end
        checks++;
    endtask

    task automatic test_zero_seed();
        seed = 48'd0; num_vec = 16'd1; stim_bus.ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        if (obs !== V0) begin errors++; $display("FAIL zseed_vec0: got %h expected %h", obs, V0); end
        checks++;
        tick();
        if (obs !== V0_D) begin errors++; $display("FAIL zseed_done_obs: got %h expected %h", obs, V0_D); end
        checks++;
        if (flags !== 2'b01) begin errors++; $display("FAIL zseed_done_flags: got %b expected %b", flags, 2'b01); end
        checks++;
    endtask

    task automatic test_backpressure();
        xfer_log.delete();
        seed = 48'd1; num_vec = 16'd3; stim_bus.ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        if (obs !== V0) begin errors++; $display("FAIL bp_vec0: got %h expected %h", obs, V0); end
        checks++;
        // Changing inputs after start must not matter.
        seed = 48'hFFFF_FFFF_FFFF; num_vec = 16'd9;
        stim_bus.ready = 1'b1;
        tick();
        if (obs !== V1) begin errors++; $display("FAIL bp_vec1: got %h expected %h", obs, V1); end
        checks++;
        stim_bus.ready = 1'b0; start = 1'b1;   // start in RUN is ignored
        tick();
        start = 1'b0;
        if (obs !== V1) begin errors++; $display("FAIL bp_hold1: got %h expected %h", obs, V1); end
        checks++;
        tick();
        if (obs !== V1) begin errors++; $display("FAIL bp_hold2: got %h expected %h", obs, V1); end
        checks++;
        stim_bus.ready = 1'b1;
        tick();
        if (obs !== V2) begin errors++; $display("FAIL bp_vec2: got %h expected %h", obs, V2); end
        checks++;
        tick();
        if (obs !== V2_D) begin errors++; $display("FAIL bp_done_obs: got %h expected %h", obs, V2_D); end
        checks++;
        if (flags !== 2'b01) begin errors++; $display("FAIL bp_done_flags: got %b expected %b", flags, 2'b01); end
        checks++;
        if (xfer_log.size() !== 3) begin
            errors++; $display("FAIL bp_xfer_count: got %0d expected 3", xfer_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (xfer_log[i] !== i) begin
                    errors++; $display("FAIL bp_xfer_order%0d: got %0d expected %0d", i, xfer_log[i], i);
                end
                checks++;
            end
        end
        checks++;
    endtask

    task automatic test_zero_count();
        seed = 48'h1234_5678_9ABC; num_vec = 16'd0; stim_bus.ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        if (stim_bus.valid !== 1'b0) begin errors++; $display("FAIL zcnt_valid: got %b expected 0", stim_bus.valid); end
        checks++;
        if (flags !== 2'b01) begin errors++; $display("FAIL zcnt_flags: got %b expected %b", flags, 2'b01); end
        checks++;
        tick();
        if (stim_bus.valid !== 1'b0) begin errors++; $display("FAIL zcnt_valid2: got %b expected 0", stim_bus.valid); end
        checks++;
        // Restart from DONE.
        num_vec = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        if (obs !== VX) begin errors++; $display("FAIL rearm_vec0: got %h expected %h", obs, VX); end
        checks++;
        if (flags !== 2'b10) begin errors++; $display("FAIL rearm_flags: got %b expected %b", flags, 2'b10); end
        checks++;
        tick();
        if (obs !== VX_D) begin errors++; $display("FAIL rearm_done_obs: got %h expected %h", obs, VX_D); end
        checks++;
        if (flags !== 2'b01) begin errors++; $display("FAIL rearm_done_flags: got %b expected %b", flags, 2'b01); end
        checks++;
    endtask

    task automatic test_reset_mid_run();
        seed = 48'd1; num_vec = 16'd10; stim_bus.ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        if (stim_bus.vec_idx !== 16'd5) begin errors++; $display("FAIL mid_idx5: got %0d expected 5", stim_bus.vec_idx); end
        checks++;
        #2;
        rst_n = 1'b0;
        #1;
        if ({obs, flags} !== 64'd0) begin errors++; $display("FAIL mid_async_clear: got %h expected %h", {obs, flags}, 64'd0); end
        checks++;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({obs, flags} !== 64'd0) begin
                errors++; $display("FAIL mid_post_idle%0d: got %h expected %h", i, {obs, flags}, 64'd0);
            end
            checks++;
        end
        num_vec = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        if (obs !== V0) begin errors++; $display("FAIL mid_restart_vec0: got %h expected %h", obs, V0); end
        checks++;
        tick();
        if (flags !== 2'b01) begin errors++; $display("FAIL mid_restart_done: got %b expected %b", flags, 2'b01); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_basic_seq();
        test_zero_seed();
        test_backpressure();
        test_zero_count();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/miter_stim_gen.md
Name: miter_stim_gen

Overview:
- Pseudo-random stimulus source for the equivalence miter harness. It drives the shared input bundle (wire0..wire3) into both design copies.
- The miter compares y_1/y_2 and consumes vectors. This block produces them, one vector per accepted handshake.
- A Galois LFSR generates a reproducible sequence from a seed, for a programmed vector count.
- It is the producer end of the harness's stimulus interface. The vector sink (clock-gating shim or checker) applies backpressure through ready.

Parameters:
- LFSR_W, 48, LFSR width. Must be ≥45, because it covers 16+10+6+13 output bits.
- TAPS, 48'hC000_0018_0000, Galois tap mask for x^48+x^47+x^21+x^20+1 (right-shift form).
- DEFAULT_SEED, 48'h0000_0000_0001, substituted whenever the seed loaded at start is all-zero.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; honoured only in IDLE or DONE.
- seed  input  LFSR_W  initial LFSR state, sampled on an accepted start.
- num_vec  input  16  vectors to emit, sampled on an accepted start.
- ready  input  1  sink accepts the current vector this cycle.
- valid  output  1  a vector is presented on wire0..wire3.
- wire0  output  16  stimulus = lfsr[15:0].
- wire1  output  10  stimulus = lfsr[25:16].
- wire2  output  6  stimulus = lfsr[31:26].
- wire3  output  13  stimulus = lfsr[44:32].
- vec_idx  output  16  index of the vector currently presented, counted from 0.
- busy  output  1  high in RUN.
- done  output  1  high in DONE; cleared by the next accepted start.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - State goes to IDLE.
  - lfsr=0, vec_idx=0, valid=0, busy=0, done=0.
  - wire0..wire3 read 0 because they are taken from lfsr.
- All outputs are registered. They are never combinational from ready or start.
- States and transitions:
  - IDLE: start → RUN if num_vec≠0; start → DONE if num_vec=0. Otherwise stay.
  - RUN: valid=1, busy=1. Any start here is ignored.
  - DONE: valid=0, done=1. start re-arms exactly as from IDLE.
- Accepted start at edge t:
  - lfsr ← (seed==0 ? DEFAULT_SEED : seed).
  - cnt_max ← num_vec−1; vec_idx ← 0; done ← 0.
  - From t+1: valid=1 and vector 0 is presented.
  - Latency from start to first valid is 1 cycle.
- Handshake (RUN):
  - Transfer occurs when valid&&ready at an edge.
  - While valid&&!ready, wire0..wire3 and vec_idx are held exactly stable.
  - On a transfer with vec_idx<cnt_max: lfsr ← (lfsr>>1) ^ (lfsr[0] ? TAPS : 0); vec_idx ← vec_idx+1. Back-to-back transfers sustain 1 vector/cycle.
  - On a transfer with vec_idx==cnt_max: state → DONE; valid ← 0; busy ← 0; done ← 1. lfsr and vec_idx hold their last values.
- Width and counting rules:
  - num_vec=16'hFFFF emits 65535 vectors; vec_idx reaches 16'hFFFE with no wrap.
  - num_vec and seed changes after start have no effect until the next accepted start.
  - The LFSR never reaches zero because the seed is forced nonzero. Period is 2^48−1.
- Simultaneous events: ready arriving in the same cycle as start (IDLE) has no effect on that cycle, because valid is still 0.
- Reset mid-RUN: immediate async clear to the reset values. No partial vector is presented after release.

Test Plan:
1. Reset then idle: assert rst_n=0 mid-cycle → valid, busy, done, wire0..wire3 and vec_idx all go to 0 asynchronously. With no start, they remain 0 for 10 cycles after release.
2. seed=1, num_vec=2, ready=1 constant → next cycle valid=1 with wire0=16'h0001, wire1=0, wire2=0, wire3=0, vec_idx=0. The following cycle wire0=0, wire1=10'h018, wire2=0, wire3=0, vec_idx=1. The cycle after that valid=0 and done=1.
3. seed=0, num_vec=1 → first vector identical to scenario 2's first vector (DEFAULT_SEED used). DONE follows after a single transfer.
4. Backpressure: num_vec=3, ready toggled 1,0,0,1,1 → wire/vec_idx stay stable on both ready=0 cycles. Exactly 3 distinct vectors transfer in the order idx 0,1,2. A start pulse during RUN is ignored.
5. num_vec=0 start → valid never asserts. done=1 one cycle after start. A restart from DONE with num_vec=1 reruns normally.
6. Reset mid-run: rst_n pulsed low at vec_idx=5 of 10 → outputs clear immediately. After release, state is IDLE and valid=0 until a new start.
